// File: rtl/text_line_renderer.sv
// Text line renderer: maps VGA pixel coordinates onto one line of 32x32 glyph cells,
// drives the glyph ROM mux and produces a registered RRGGBB pixel two clocks later.
module text_line_renderer #(
    parameter int unsigned NUM_CHARS = 16,
    parameter logic [9:0]  TEXT_X0   = 10'd64,
    parameter logic [9:0]  TEXT_Y0   = 10'd224,
    parameter logic [5:0]  FG_COLOR  = 6'b000000,
    parameter logic [5:0]  BG_COLOR  = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_char,
    output logic [5:0] glyph_code,
    output logic [4:0] glyph_col,
    output logic [4:0] glyph_row,
    input  logic [5:0] glyph_data,
    output logic [5:0] rgb,
    output logic       rgb_valid
);

    // 11-bit bounds so a text line near the right/bottom edge cannot wrap at 1023
    localparam logic [10:0] X_LO  = {1'b0, TEXT_X0};
    localparam logic [10:0] X_HI  = X_LO + 11'(32 * NUM_CHARS);
    localparam logic [10:0] Y_LO  = {1'b0, TEXT_Y0};
    localparam logic [10:0] Y_HI  = Y_LO + 11'd32;
    localparam logic [4:0]  CELLS = 5'(NUM_CHARS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DIRTY = 1'b1;

    logic [0:0] buf_state;
    logic [5:0] active  [16];
    logic [5:0] pending [16];

    logic [8:0] dx;
    logic [4:0] dy;
    logic       in_text;
    logic       wr_ok;
    logic       do_swap;
    logic       vis1;
    logic       txt1;

    always_comb begin
        dx      = pixel_x[8:0] - TEXT_X0[8:0];
        dy      = pixel_y[4:0] - TEXT_Y0[4:0];
        in_text = video_on
                  && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
                  && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
        wr_ok   = wr_en && ({1'b0, wr_addr} < CELLS);
        do_swap = frame_start && (buf_state == ST_DIRTY);
    end

    // Swap copies the pre-edge pending contents; a coincident write lands afterwards
    // and keeps the buffer dirty for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                active[4'(i)]  <= '0;
                pending[4'(i)] <= '0;
            end
            buf_state <= ST_IDLE;
        end else begin
            if (do_swap) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    active[4'(i)] <= pending[4'(i)];
                end
            end
            if (wr_ok) begin
                pending[wr_addr] <= wr_char;
            end
            if (wr_ok) begin
                buf_state <= ST_DIRTY;
            end else if (do_swap) begin
                buf_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glyph_code <= '0;
            glyph_col  <= '0;
            glyph_row  <= '0;
            vis1       <= 1'b0;
            txt1       <= 1'b0;
        end else begin
            glyph_code <= in_text ? active[dx[8:5]] : '0;
            glyph_col  <= dx[4:0];
            glyph_row  <= dy;
            vis1       <= video_on;
            txt1       <= in_text;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= BG_COLOR;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= vis1;
            if (vis1 && txt1 && (glyph_code != '0) && (glyph_data == '0)) begin
                rgb <= FG_COLOR;
            end else begin
                rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed self-checking bench for text_line_renderer with a behavioural glyph ROM
// and a reference pixel model for the streaming sweep.
module tb_text_line_renderer;

    localparam int NC = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_start;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_char;
    logic [5:0] glyph_code;
    logic [4:0] glyph_col;
    logic [4:0] glyph_row;
    logic [5:0] glyph_data;
    logic [5:0] rgb;
    logic       rgb_valid;

    int n_cmp = 0;
    int n_err = 0;
    bit rom_mode = 1'b0;
    int act_m [16];
    int pend_m [16];
    bit dirty_m = 1'b0;
    logic [6:0] exp_q [$];

    text_line_renderer #(.NUM_CHARS(NC)) dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .glyph_code(glyph_code),
        .glyph_col(glyph_col), .glyph_row(glyph_row), .glyph_data(glyph_data),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] rom_fn(input logic [5:0] code, input logic [4:0] col,
                                          input logic [4:0] row);
        if ((int'(col) + 2 * int'(row) + int'(code)) % 4 == 0) return 6'b000000;
        return {row[2:0], col[2:0]} | 6'b000001;
    endfunction

    always_comb begin
        glyph_data = rom_mode ? rom_fn(glyph_code, glyph_col, glyph_row) : 6'b000000;
    end

    function automatic logic [6:0] ref_pix(input int x, input int y, input bit v);
        int code;
        if (!v) return {1'b0, 6'h3F};
        if (!(x >= 64 && x < 64 + 32 * NC && y >= 224 && y < 256)) return {1'b1, 6'h3F};
        code = act_m[(x - 64) / 32];
        if (code != 0 && rom_fn(6'(code), 5'((x - 64) % 32), 5'((y - 224) % 32)) == 6'd0)
            return {1'b1, 6'h00};
        return {1'b1, 6'h3F};
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input bit v);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
    endtask

    task automatic wr(input int a, input int c);
        wr_en = 1'b1; wr_addr = 4'(a); wr_char = 6'(c);
        step();
        wr_en = 1'b0;
        if (a < NC) begin
            pend_m[a] = c;
            dirty_m   = 1'b1;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        if (dirty_m) begin
            act_m   = pend_m;
            dirty_m = 1'b0;
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp_code);
        pix(x, y, 1'b1);
        step();
        chk(tag, int'(glyph_code), exp_code);
    endtask

    task automatic rgbchk(input string tag, input int x, input int y, input bit v,
                          input int exp_rgb, input int exp_valid);
        pix(x, y, v);
        step();
        step();
        chk({tag, "_rgb"}, int'(rgb), exp_rgb);
        chk({tag, "_vld"}, int'(rgb_valid), exp_valid);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            act_m[i] = 0;
            pend_m[i] = 0;
        end
        reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
        pix(0, 0, 1'b1);

        // T1 reset
        step(); step(); step();
        chk("rst_rgb", int'(rgb), 'h3F);
        chk("rst_vld", int'(rgb_valid), 0);
        chk("rst_code", int'(glyph_code), 0);
        reset = 1'b0;
        step();
        chk("rel_rgb", int'(rgb), 'h3F);
        chk("rel_vld", int'(rgb_valid), 0);

        // T2 latency and mapping
        wr(2, 5);
        frame();
        pix(131, 228, 1'b1);
        step();
        chk("lat_code", int'(glyph_code), 5);
        chk("lat_col", int'(glyph_col), 3);
        chk("lat_row", int'(glyph_row), 4);
        step();
        chk("lat_rgb", int'(rgb), 'h00);
        chk("lat_vld", int'(rgb_valid), 1);

        // T3 region bounds
        wr(0, 3);
        wr(11, 9);
        frame();
        rgbchk("x_lo_m1", 63, 228, 1'b1, 'h3F, 1);
        rgbchk("x_hi", 64 + 32 * NC, 228, 1'b1, 'h3F, 1);
        rgbchk("y_hi", 131, 256, 1'b1, 'h3F, 1);
        rgbchk("y_lo_m1", 131, 223, 1'b1, 'h3F, 1);
        rgbchk("x_lo_ink", 64, 228, 1'b1, 'h00, 1);
        probe("x_lo_code", 64, 228, 3);
        probe("x_hi_m1_code", 64 + 32 * NC - 1, 228, 9);
        chk("x_hi_m1_col", int'(glyph_col), 31);
        rgbchk("x_hi_m1_ink", 64 + 32 * NC - 1, 255, 1'b1, 'h00, 1);

        // T4 double buffering
        wr(0, 7);
        probe("db_old", 64, 228, 3);
        frame();
        probe("db_new", 64, 228, 7);
        wr(1, 4);
        wr_en = 1'b1; wr_addr = 4'd0; wr_char = 6'd8; frame_start = 1'b1;
        step();
        wr_en = 1'b0; frame_start = 1'b0;
        act_m = pend_m;
        pend_m[0] = 8;
        probe("sw_c1", 96, 228, 4);
        probe("sw_c0", 64, 228, 7);
        frame();
        probe("sw_late", 64, 228, 8);

        // T5 edge cases
        probe("code0", 226, 228, 0);
        rgbchk("code0", 226, 228, 1'b1, 'h3F, 1);
        wr(NC, 9);
        frame();
        probe("oob_c0", 64, 228, 8);
        probe("oob_cell", 64 + 32 * NC + 5, 228, 0);
        pix(64, 228, 1'b0);
        step();
        chk("vis0_code", int'(glyph_code), 0);
        step();
        chk("vis0_rgb", int'(rgb), 'h3F);
        chk("vis0_vld", int'(rgb_valid), 0);

        // T6 streaming sweep across and around the text line
        for (int i = 0; i < NC; i++) wr(i, (i == 5) ? 0 : i + 1);
        frame();
        rom_mode = 1'b1;
        for (int y = 218; y < 262; y++) begin
            for (int x = 0; x < 800; x++) begin
                pix(x, y, x < 640);
                exp_q.push_back(ref_pix(x, y, x < 640));
                step();
                if (exp_q.size() == 2) chk("stream", int'({rgb_valid, rgb}), int'(exp_q.pop_front()));
            end
        end
        step();
        chk("stream_tail", int'({rgb_valid, rgb}), int'(exp_q.pop_front()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
